// File: rtl/dwb_stage_hs.sv
// rtl/dwb_stage_hs.sv - RV32I data-memory/writeback stage with req/ack memory handshake and timeout
// Optional MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of silently aligning them down.
module dwb_stage_hs #(
  parameter int AW      = 12,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          memRD,
  input  logic          memWR,
  input  logic [2:0]    memCtrl,
  input  logic [1:0]    wbCtrl,
  input  logic          regWrite,
  input  logic [4:0]    rd,
  input  logic [31:0]   pcN,
  input  logic [31:0]   aluOut,
  input  logic [31:0]   dataIn,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic          wb_valid,
  output logic          wb_we,
  output logic [4:0]    wb_rd,
  output logic [31:0]   wbOut,
`ifdef MISALIGN_TRAP_EN
  output logic          misalign,
`endif
  output logic          mem_err
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam bit            TO_EN   = (TIMEOUT > 0);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // memCtrl[1:0]: 00 byte, 01 half, 1x word; memCtrl[2] selects zero-extension for B/H
  function automatic logic [3:0] store_be(input logic [2:0] c, input logic [1:0] a);
    case (c[1:0])
      2'b00:   store_be = 4'b0001 << a;
      2'b01:   store_be = 4'b0011 << {a[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] c, input logic [31:0] d);
    case (c[1:0])
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] c, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (c[1:0])
      2'b00:   load_ext = c[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = c[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_ext = d;
    endcase
  endfunction

  function automatic logic [31:0] wb_sel(input logic [1:0] s, input logic [31:0] pcn,
                                         input logic [31:0] alu, input logic [31:0] ld);
    case (s)
      2'b00:   wb_sel = pcn;
      2'b01:   wb_sel = alu;
      2'b10:   wb_sel = ld;
      default: wb_sel = 32'h0;
    endcase
  endfunction

  state_t        state, state_nxt;
  logic          go_wait, go_direct, ack_done, to_done;
  logic          in_mem, in_store, trap;
  logic [CW-1:0] cnt;

  logic [4:0]    l_rd;
  logic          l_reg_write;
  logic [1:0]    l_wb_ctrl;
  logic [2:0]    l_mem_ctrl;
  logic [31:0]   l_pcn;
  logic [31:0]   l_alu;
  logic          l_store;

  assign in_mem   = memRD | memWR;
  assign in_store = memWR & ~memRD;
  assign in_ready = (state == S_IDLE);

`ifdef MISALIGN_TRAP_EN
  assign trap = in_mem && (((memCtrl[1:0] == 2'b01) && aluOut[0]) ||
                           (memCtrl[1] && (aluOut[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go_wait   = 1'b0;
    go_direct = 1'b0;
    ack_done  = 1'b0;
    to_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (in_mem && !trap) begin
            go_wait   = 1'b1;
            state_nxt = S_WAIT;
          end else begin
            go_direct = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // ack is checked first so a same-cycle ack beats the timeout
        if (mem_ack) begin
          ack_done  = 1'b1;
          state_nxt = S_IDLE;
        end else if (TO_EN && (cnt == TO_LAST)) begin
          to_done   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= 4'h0;
      mem_wdata   <= 32'h0;
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= 5'd0;
      wbOut       <= 32'h0;
      mem_err     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign    <= 1'b0;
`endif
      cnt         <= '0;
      l_rd        <= 5'd0;
      l_reg_write <= 1'b0;
      l_wb_ctrl   <= 2'b00;
      l_mem_ctrl  <= 3'b000;
      l_pcn       <= 32'h0;
      l_alu       <= 32'h0;
      l_store     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
      if (state == S_WAIT) cnt <= cnt + 1'b1;

      if ((state == S_IDLE) && in_valid) begin
        l_rd        <= rd;
        l_reg_write <= regWrite;
        l_wb_ctrl   <= wbCtrl;
        l_mem_ctrl  <= memCtrl;
        l_pcn       <= pcN;
        l_alu       <= aluOut;
        l_store     <= in_store;
      end

      if (go_wait) begin
        mem_req   <= 1'b1;
        mem_we    <= in_store;
        mem_addr  <= {aluOut[AW-1:2], 2'b00};
        mem_be    <= store_be(memCtrl, aluOut[1:0]);
        mem_wdata <= store_data(memCtrl, dataIn);
        cnt       <= '0;
      end

      if (go_direct) begin
        wb_valid <= 1'b1;
        wb_rd    <= rd;
        if (trap) begin
          wbOut    <= aluOut;
`ifdef MISALIGN_TRAP_EN
          misalign <= 1'b1;
`endif
        end else begin
          wb_we <= regWrite && (rd != 5'd0);
          wbOut <= wb_sel(wbCtrl, pcN, aluOut, 32'h0);
        end
      end

      if (ack_done) begin
        mem_req  <= 1'b0;
        wb_valid <= 1'b1;
        wb_rd    <= l_rd;
        wb_we    <= !l_store && l_reg_write && (l_rd != 5'd0);
        wbOut    <= wb_sel(l_wb_ctrl, l_pcn, l_alu,
                           load_ext(l_mem_ctrl, l_alu[1:0], mem_rdata));
      end

      if (to_done) begin
        mem_req  <= 1'b0;
        mem_err  <= 1'b1;
        wb_valid <= 1'b1;
        wb_rd    <= l_rd;
      end
    end
  end

endmodule

// File: tb/tb_dwb_stage_hs.sv
// tb/tb_dwb_stage_hs.sv - randomized self-checking bench for dwb_stage_hs against a behavioural model
module tb_dwb_stage_hs;
  localparam int AW = 12;
  localparam int TO = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, memRD, memWR, regWrite;
  logic [2:0]    memCtrl;
  logic [1:0]    wbCtrl;
  logic [4:0]    rd, wb_rd;
  logic [31:0]   pcN, aluOut, dataIn, mem_wdata, mem_rdata, wbOut;
  logic          mem_req, mem_we, mem_ack, wb_valid, wb_we, mem_err;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
`ifdef MISALIGN_TRAP_EN
  logic          misalign;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic err_model = 1'b0;

  always #5 clk = ~clk;

  dwb_stage_hs #(.AW(AW), .TIMEOUT(TO), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .memRD(memRD), .memWR(memWR), .memCtrl(memCtrl), .wbCtrl(wbCtrl),
    .regWrite(regWrite), .rd(rd), .pcN(pcN), .aluOut(aluOut), .dataIn(dataIn),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wbOut(wbOut),
`ifdef MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .mem_err(mem_err)
  );

  function automatic logic [31:0] m_load(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    if (c == 3'b000 || c == 3'b100) begin
      v = (d >> ((a % 4) * 8)) & 32'hFF;
      if (c == 3'b000 && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (c == 3'b001 || c == 3'b101) begin
      v = (d >> (((a % 4) / 2) * 16)) & 32'hFFFF;
      if (c == 3'b001 && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] c, input logic [31:0] a);
    if (c == 3'b000 || c == 3'b100) return 4'(1 << (a % 4));
    if (c == 3'b001 || c == 3'b101) return 4'(3 << (((a % 4) / 2) * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] c, input logic [31:0] d);
    if (c == 3'b000 || c == 3'b100) return (d % 256) * 32'h0101_0101;
    if (c == 3'b001 || c == 3'b101) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_wb(input logic [1:0] s, input logic [31:0] pcn, input logic [31:0] alu, input logic [31:0] ld);
    case (s)
      2'd0:    return pcn;
      2'd1:    return alu;
      2'd2:    return ld;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic r, input logic w, input logic [2:0] c, input logic [1:0] s,
                       input logic rw, input logic [4:0] rdn, input logic [31:0] pcn,
                       input logic [31:0] a, input logic [31:0] din);
    @(negedge clk);
    in_valid = 1'b1; memRD = r; memWR = w; memCtrl = c; wbCtrl = s;
    regWrite = rw; rd = rdn; pcN = pcn; aluOut = a; dataIn = din;
    @(posedge clk); #1;
    in_valid = 1'b0; memRD = 1'b0; memWR = 1'b0;
  endtask

  task automatic do_alu(input logic [1:0] s, input logic rw, input logic [4:0] rdn,
                        input logic [31:0] pcn, input logic [31:0] a, input string tag);
    logic [31:0] e_out;
    logic        e_we;
    drive(1'b0, 1'b0, 3'b010, s, rw, rdn, pcn, a, $urandom);
    e_out = m_wb(s, pcn, a, 32'h0);
    e_we  = rw && (rdn != 0);
    total_cnt++;
    if (wb_valid !== 1'b1 || wbOut !== e_out || wb_we !== e_we || wb_rd !== rdn ||
        mem_req !== 1'b0 || in_ready !== 1'b1 || mem_err !== err_model)
      $display("FAIL %s alu: valid=%b out=%h we=%b rd=%0d req=%b rdy=%b err=%b, want valid=1 out=%h we=%b rd=%0d req=0 rdy=1 err=%b",
               tag, wb_valid, wbOut, wb_we, wb_rd, mem_req, in_ready, mem_err, e_out, e_we, rdn, err_model);
    else pass_cnt++;
  endtask

  // delay = wait cycles without ack before the ack cycle; delay >= TO means the ack never comes in time
  task automatic do_mem(input logic r, input logic w, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] din, input logic [1:0] s, input logic rw,
                        input logic [4:0] rdn, input logic [31:0] pcn, input logic [31:0] rdata,
                        input int delay, input string tag);
    logic [AW-1:0] e_addr;
    logic [3:0]    e_be;
    logic [31:0]   e_wd, e_out;
    logic          e_st, e_we;
    e_st   = w && !r;
    e_addr = AW'((a % 4096) / 4 * 4);
    e_be   = m_be(c, a);
    e_wd   = m_wdata(c, din);
    drive(r, w, c, s, rw, rdn, pcn, a, din);
`ifdef MISALIGN_TRAP_EN
    if (((c == 3'b001 || c == 3'b101) && a % 2 != 0) || (c[1] && a % 4 != 0)) begin
      total_cnt++;
      if (mem_req !== 1'b0 || wb_valid !== 1'b1 || wb_we !== 1'b0 || misalign !== 1'b1 || wbOut !== a)
        $display("FAIL %s trap: req=%b valid=%b we=%b mis=%b out=%h, want req=0 valid=1 we=0 mis=1 out=%h",
                 tag, mem_req, wb_valid, wb_we, misalign, wbOut, a);
      else pass_cnt++;
      return;
    end
`endif
    total_cnt++;
    if (mem_req !== 1'b1 || mem_we !== e_st || mem_addr !== e_addr || mem_be !== e_be ||
        mem_wdata !== e_wd || in_ready !== 1'b0 || wb_valid !== 1'b0)
      $display("FAIL %s issue: req=%b we=%b addr=%h be=%b wd=%h rdy=%b v=%b, want req=1 we=%b addr=%h be=%b wd=%h rdy=0 v=0",
               tag, mem_req, mem_we, mem_addr, mem_be, mem_wdata, in_ready, wb_valid, e_st, e_addr, e_be, e_wd);
    else pass_cnt++;
    for (int i = 1; i <= delay && i <= TO; i++) begin
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
      @(posedge clk); #1;
      total_cnt++;
      if (i == TO) begin
        err_model = 1'b1;
        if (mem_req !== 1'b0 || mem_err !== 1'b1 || wb_valid !== 1'b1 || wb_we !== 1'b0 || in_ready !== 1'b1)
          $display("FAIL %s timeout: req=%b err=%b valid=%b we=%b rdy=%b, want req=0 err=1 valid=1 we=0 rdy=1",
                   tag, mem_req, mem_err, wb_valid, wb_we, in_ready);
        else pass_cnt++;
      end else begin
        if (mem_req !== 1'b1 || mem_addr !== e_addr || mem_be !== e_be || mem_wdata !== e_wd ||
            in_ready !== 1'b0 || wb_valid !== 1'b0)
          $display("FAIL %s wait%0d: req=%b addr=%h be=%b rdy=%b v=%b, want req=1 addr=%h be=%b rdy=0 v=0",
                   tag, i, mem_req, mem_addr, mem_be, in_ready, wb_valid, e_addr, e_be);
        else pass_cnt++;
      end
    end
    if (delay < TO) begin
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = rdata;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      e_out = m_wb(s, pcn, a, m_load(c, a, rdata));
      e_we  = !e_st && rw && (rdn != 0);
      total_cnt++;
      if (mem_req !== 1'b0 || wb_valid !== 1'b1 || wbOut !== e_out || wb_we !== e_we ||
          wb_rd !== rdn || in_ready !== 1'b1 || mem_err !== err_model)
        $display("FAIL %s done: req=%b v=%b out=%h we=%b rd=%0d rdy=%b err=%b, want req=0 v=1 out=%h we=%b rd=%0d rdy=1 err=%b",
                 tag, mem_req, wb_valid, wbOut, wb_we, wb_rd, in_ready, mem_err, e_out, e_we, rdn, err_model);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_be !== 4'h0 ||
        mem_wdata !== 32'h0 || wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_rd !== 5'd0 ||
        wbOut !== 32'h0 || mem_err !== 1'b0)
      $display("FAIL reset: rdy=%b req=%b we=%b addr=%h be=%b wd=%h v=%b wwe=%b rd=%0d out=%h err=%b, want rdy=1 rest 0",
               in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_valid, wb_we, wb_rd, wbOut, mem_err);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_alu();
    do_alu(2'b01, 1'b1, 5'd5, 32'h0000_0104, 32'h1234_5678, "alu_basic");
    @(posedge clk); #1;
    total_cnt++;
    if (wb_valid !== 1'b0 || wb_we !== 1'b0)
      $display("FAIL alu_pulse: valid=%b we=%b, want 0 0", wb_valid, wb_we);
    else pass_cnt++;
    do_alu(2'b00, 1'b1, 5'd0, 32'h0000_0200, 32'hAAAA_5555, "alu_rd0");
    do_alu(2'b11, 1'b1, 5'd31, 32'h0000_0300, 32'hFFFF_FFFF, "alu_zero");
  endtask

  task automatic test_load();
    do_mem(1'b1, 1'b0, 3'b000, 32'h003, 32'h0, 2'b10, 1'b1, 5'd7, 32'h10, 32'h8000_0000, 3, "lb");
    do_mem(1'b1, 1'b0, 3'b100, 32'h003, 32'h0, 2'b10, 1'b1, 5'd7, 32'h14, 32'h8000_0000, 3, "lbu");
    do_mem(1'b1, 1'b0, 3'b001, 32'h002, 32'h0, 2'b10, 1'b1, 5'd8, 32'h18, 32'h9ABC_1234, 0, "lh");
    do_mem(1'b1, 1'b0, 3'b101, 32'h002, 32'h0, 2'b10, 1'b1, 5'd8, 32'h1C, 32'h9ABC_1234, 1, "lhu");
  endtask

  task automatic test_store();
    do_mem(1'b0, 1'b1, 3'b001, 32'h0A2, 32'hDEAD_BEEF, 2'b00, 1'b1, 5'd3, 32'h20, 32'h0, 0, "sh");
    do_mem(1'b0, 1'b1, 3'b000, 32'h0A1, 32'hDEAD_BEEF, 2'b01, 1'b1, 5'd3, 32'h24, 32'h0, 2, "sb");
    do_mem(1'b1, 1'b1, 3'b010, 32'h0B0, 32'h1111_2222, 2'b10, 1'b1, 5'd4, 32'h28, 32'hCAFE_F00D, 1, "rdwr");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, din, pcn, rdata;
    logic [2:0]  c;
    logic [1:0]  s;
    logic [4:0]  rdn;
    int          kind;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      a = $urandom; din = $urandom; pcn = $urandom; rdata = $urandom;
      c = 3'($urandom); s = 2'($urandom); rdn = 5'($urandom);
      if (kind == 0) begin
        if (s == 2'b10) s = 2'b01;
        do_alu(s, 1'($urandom), rdn, pcn, a, "rnd_alu");
      end else begin
        do_mem(kind != 2, kind >= 2, c, a, din, s, 1'($urandom), rdn, pcn, rdata,
               $urandom_range(0, TO - 1), "rnd_mem");
      end
    end
  endtask

  task automatic test_timeout();
    do_mem(1'b1, 1'b0, 3'b010, 32'h040, 32'h0, 2'b10, 1'b1, 5'd6, 32'h30, 32'h0, 10, "lw_timeout");
    do_alu(2'b01, 1'b1, 5'd9, 32'h34, 32'h0BAD_F00D, "alu_after_to");
  endtask

  task automatic test_rst_mid_wait();
    drive(1'b1, 1'b0, 3'b010, 2'b10, 1'b1, 5'd9, 32'h40, 32'h100, 32'h0);
    total_cnt++;
    if (mem_req !== 1'b1) $display("FAIL rst_wait_req: req=%b want 1", mem_req);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    err_model = 1'b0;
    total_cnt++;
    if (mem_req !== 1'b0 || in_ready !== 1'b1 || mem_err !== 1'b0)
      $display("FAIL rst_async: req=%b rdy=%b err=%b, want 0 1 0", mem_req, in_ready, mem_err);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    total_cnt++;
    if (wb_valid !== 1'b0 || mem_req !== 1'b0 || mem_err !== 1'b0)
      $display("FAIL stray_ack: valid=%b req=%b err=%b, want 0 0 0", wb_valid, mem_req, mem_err);
    else pass_cnt++;
  endtask

  task automatic test_misalign();
    do_mem(1'b1, 1'b0, 3'b010, 32'h006, 32'h0, 2'b10, 1'b1, 5'd10, 32'h50, 32'h7654_3210, 1, "lw_mis");
`ifdef MISALIGN_TRAP_EN
    @(posedge clk); #1;
    total_cnt++;
    if (misalign !== 1'b0) $display("FAIL misalign_pulse: mis=%b want 0", misalign);
    else pass_cnt++;
`endif
    do_mem(1'b1, 1'b0, 3'b001, 32'h00B, 32'h0, 2'b10, 1'b1, 5'd11, 32'h54, 32'hF00F_8001, 0, "lh_mis");
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; memRD = 1'b0; memWR = 1'b0; memCtrl = 3'b0; wbCtrl = 2'b0;
    regWrite = 1'b0; rd = 5'd0; pcN = 32'h0; aluOut = 32'h0; dataIn = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_timeout();
    test_rst_mid_wait();
    test_misalign();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
